mirror_router: RTL and testbench

- Parametrised N-channel sample router/scaler for the eurorack-pmod gateware.
- Once per audio frame it routes any input to any output, applies a signed power-of-two gain per output (attenuate with arithmetic shift, boost with saturation), and supports per-output mute.
- It processes one channel per clk through a single shared shifter, then commits all outputs at once.
- Sits between the codec sample interface and downstream DSP cores.

---
 rtl/mirror_router_if.sv | 49 ++++
 rtl/mirror_router.sv | 190 +++++++++++++++++++
 tb/tb_mirror_router.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mirror_router_if.sv
`default_nettype none
// ============================================================================
// mirror_router_if : frame-strobed sample and routing-config bus for
//                    mirror_router. cfg_crush exists only with
//                    MIRROR_ROUTER_CRUSH_EN defined.
// Revision: 1.0
// ============================================================================
interface mirror_router_if #(
    parameter int W       = 16,
    parameter int N_CH    = 4,
    parameter int SHIFT_W = 3
);
    localparam int SI = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                          sample_clk;
    logic [N_CH*W-1:0]             sample_in;
    logic [N_CH*SI-1:0]            cfg_src;
    logic [N_CH*(SHIFT_W+1)-1:0]   cfg_shift;
    logic [N_CH-1:0]               cfg_mute;
    logic [7:0]                    jack;
`ifdef MIRROR_ROUTER_CRUSH_EN
    logic [N_CH*4-1:0]             cfg_crush;
`endif
    logic [N_CH*W-1:0]             sample_out;
    logic                          busy;
    logic                          frame_valid;
    logic                          overrun;

`ifdef MIRROR_ROUTER_CRUSH_EN
    modport master (
        output sample_clk, sample_in, cfg_src, cfg_shift, cfg_mute, jack, cfg_crush,
        input  sample_out, busy, frame_valid, overrun
    );
    modport slave (
        input  sample_clk, sample_in, cfg_src, cfg_shift, cfg_mute, jack, cfg_crush,
        output sample_out, busy, frame_valid, overrun
    );
`else
    modport master (
        output sample_clk, sample_in, cfg_src, cfg_shift, cfg_mute, jack,
        input  sample_out, busy, frame_valid, overrun
    );
    modport slave (
        input  sample_clk, sample_in, cfg_src, cfg_shift, cfg_mute, jack,
        output sample_out, busy, frame_valid, overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mirror_router.sv
`default_nettype none
// ============================================================================
// mirror_router : per-frame N-channel sample router with power-of-two gain,
//                 saturation and mute through one shared per-clk shifter.
//                 Optional bit-crush stage: MIRROR_ROUTER_CRUSH_EN.
// Revision: 1.0
// ============================================================================
module mirror_router #(
    parameter int W       = 16,
    parameter int N_CH    = 4,
    parameter int SHIFT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    mirror_router_if.slave bus
);
    localparam int SI = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = SI;
    localparam int KW = SHIFT_W + 1;
    localparam int WL = W + (1 << SHIFT_W);
    localparam int AW = $clog2(W);
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sclk_q;
    logic [CW-1:0]       ch_q, ch_d;
    logic [N_CH*W-1:0]   in_q;
    logic [N_CH*SI-1:0]  src_q;
    logic [N_CH*KW-1:0]  shift_q;
    logic [N_CH-1:0]     mute_q;
    logic [7:0]          jack_q;
`ifdef MIRROR_ROUTER_CRUSH_EN
    logic [N_CH*4-1:0]   crush_q;
    logic [3:0]          c_f;
    logic [AW-1:0]       camt;
`endif
    logic [N_CH*W-1:0]   stage_q, stage_d;
    logic [N_CH*W-1:0]   out_q, out_d;
    logic                fv_q, fv_d;
    logic                ovr_q, ovr_d;
    logic                rise;
    logic                capture;

    logic [SI-1:0]       src_f;
    logic signed [KW-1:0] k_f;
    logic                src_ok;
    int                  src_idx;
    int                  k_int;
    int                  mag;
    logic [AW-1:0]       amt;
    logic signed [W-1:0] x_sel;
    logic signed [W-1:0] rsh;
    logic signed [WL-1:0] x_ext;
    logic signed [WL-1:0] lsh;
    logic [WL-W:0]       lsh_hi;
    logic signed [W-1:0] g_val;
    logic signed [W-1:0] y_val;

    assign rise = bus.sample_clk & ~sclk_q;

    // Shared datapath: evaluates the channel selected by ch_q from the snapshot.
    always_comb begin
        src_f   = src_q[int'(ch_q)*SI +: SI];
        k_f     = shift_q[int'(ch_q)*KW +: KW];
        src_ok  = (int'(src_f) < N_CH) && jack_q[src_f];
        src_idx = src_ok ? int'(src_f) : 0;
        x_sel   = src_ok ? in_q[src_idx*W +: W] : '0;

        k_int = int'(k_f);
        mag   = (k_int < 0) ? -k_int : k_int;
        amt   = (mag > W - 1) ? AW'(W - 1) : AW'(mag);

        x_ext  = {{(WL-W){x_sel[W-1]}}, x_sel};
        rsh    = x_sel >>> amt;
        lsh    = x_ext <<< amt;
        lsh_hi = lsh[WL-1:W-1];

        // Any disagreement among the bits above the output sign means lost magnitude.
        if (k_int < 0) begin
            g_val = rsh;
        end else if (k_int == 0) begin
            g_val = x_sel;
        end else if ((lsh_hi == '0) || (lsh_hi == '1)) begin
            g_val = lsh[W-1:0];
        end else begin
            g_val = lsh[WL-1] ? SAT_MIN : SAT_MAX;
        end

`ifdef MIRROR_ROUTER_CRUSH_EN
        c_f   = crush_q[int'(ch_q)*4 +: 4];
        camt  = (int'(c_f) > W - 1) ? AW'(W - 1) : AW'(c_f);
        y_val = (g_val >>> camt) <<< camt;
`else
        y_val = g_val;
`endif
        if (mute_q[ch_q]) begin
            y_val = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        stage_d = stage_q;
        out_d   = out_q;
        fv_d    = 1'b0;
        capture = 1'b0;
        // COMMIT also counts as busy, so a rise there is dropped as an overrun.
        ovr_d   = ovr_q | (rise & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    ch_d    = '0;
                    state_d = S_PROC;
                end
            end
            S_PROC: begin
                stage_d[int'(ch_q)*W +: W] = y_val;
                if (int'(ch_q) == N_CH - 1) begin
                    ch_d    = '0;
                    state_d = S_COMMIT;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            S_COMMIT: begin
                out_d   = stage_q;
                fv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sclk_q  <= 1'b0;
            ch_q    <= '0;
            in_q    <= '0;
            src_q   <= '0;
            shift_q <= '0;
            mute_q  <= '0;
            jack_q  <= '0;
`ifdef MIRROR_ROUTER_CRUSH_EN
            crush_q <= '0;
`endif
            stage_q <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= bus.sample_clk;
            ch_q    <= ch_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            fv_q    <= fv_d;
            ovr_q   <= ovr_d;
            if (capture) begin
                in_q    <= bus.sample_in;
                src_q   <= bus.cfg_src;
                shift_q <= bus.cfg_shift;
                mute_q  <= bus.cfg_mute;
                jack_q  <= bus.jack;
`ifdef MIRROR_ROUTER_CRUSH_EN
                crush_q <= bus.cfg_crush;
`endif
            end
        end
    end

    assign bus.sample_out  = out_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_valid = fv_q;
    assign bus.overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_mirror_router.sv
`default_nettype none
// ============================================================================
// tb_mirror_router : table vectors, corner sequences and randomized frames
//                    against an integer-arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_mirror_router;
    localparam int W       = 16;
    localparam int N_CH    = 4;
    localparam int SHIFT_W = 3;
    localparam int SI      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KW      = SHIFT_W + 1;
    localparam int MAXV    = (1 << (W - 1)) - 1;
    localparam int MINV    = -(1 << (W - 1));

    logic clk;
    logic rst;

    mirror_router_if #(.W(W), .N_CH(N_CH), .SHIFT_W(SHIFT_W)) bus ();
    mirror_router_if #(.W(W), .N_CH(3),    .SHIFT_W(SHIFT_W)) bus3 ();

    mirror_router #(.W(W), .N_CH(N_CH), .SHIFT_W(SHIFT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mirror_router #(.W(W), .N_CH(3), .SHIFT_W(SHIFT_W)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [N_CH*W-1:0]  sin;
        logic [N_CH*SI-1:0] src;
        logic [N_CH*KW-1:0] shift;
        logic [N_CH-1:0]    mute;
        logic [7:0]         jack;
        logic [N_CH*W-1:0]  exp;
    } vec_t;

    vec_t tbl [8];

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] in_v    [N_CH];
    int           src_v   [N_CH];
    int           shift_v [N_CH];
    bit           mute_v  [N_CH];
    int           crush_v [N_CH];
    logic [7:0]   jack_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic [N_CH*W-1:0] sin, input logic [N_CH*SI-1:0] src,
                           input logic [N_CH*KW-1:0] sh, input logic [N_CH-1:0] mu,
                           input logic [7:0] jk);
        bus.sample_in = sin;
        bus.cfg_src   = src;
        bus.cfg_shift = sh;
        bus.cfg_mute  = mu;
        bus.jack      = jk;
`ifdef MIRROR_ROUTER_CRUSH_EN
        bus.cfg_crush = '0;
`endif
    endtask

    task automatic drive_model_inputs();
        logic [31:0] t;
        for (int i = 0; i < N_CH; i++) begin
            bus.sample_in[i*W +: W] = in_v[i];
            t = src_v[i];
            bus.cfg_src[i*SI +: SI] = t[SI-1:0];
            t = shift_v[i];
            bus.cfg_shift[i*KW +: KW] = t[KW-1:0];
            bus.cfg_mute[i] = mute_v[i];
`ifdef MIRROR_ROUTER_CRUSH_EN
            t = crush_v[i];
            bus.cfg_crush[i*4 +: 4] = t[3:0];
`endif
        end
        bus.jack = jack_v;
    endtask

    task automatic scramble_inputs();
        bus.sample_in = {$urandom, $urandom};
        bus.cfg_src   = 8'($urandom);
        bus.cfg_shift = 16'($urandom);
        bus.cfg_mute  = 4'($urandom);
        bus.jack      = 8'($urandom);
`ifdef MIRROR_ROUTER_CRUSH_EN
        bus.cfg_crush = 16'($urandom);
`endif
    endtask

    // Reference: route, gain with floor/saturation, crush, mute in plain integers.
    function automatic logic [W-1:0] model_ch(input int ch);
        int s;
        int v;
        int a;
        logic [W-1:0] r;
        s = src_v[ch];
        if (s >= N_CH) v = 0;
        else if (jack_v[s] == 1'b0) v = 0;
        else v = int'($signed(in_v[s]));
        if (shift_v[ch] < 0) begin
            a = -shift_v[ch];
            if (a > W - 1) a = W - 1;
            v = v >>> a;
        end else if (shift_v[ch] > 0) begin
            a = shift_v[ch];
            if (a > W - 1) a = W - 1;
            v = v * (1 << a);
            if (v > MAXV) v = MAXV;
            if (v < MINV) v = MINV;
        end
`ifdef MIRROR_ROUTER_CRUSH_EN
        a = crush_v[ch];
        if (a > W - 1) a = W - 1;
        v = (v >>> a) * (1 << a);
`endif
        if (mute_v[ch]) v = 0;
        r = v[W-1:0];
        return r;
    endfunction

    // Called #1 after a posedge; the next posedge is the capture edge.
    task automatic do_frame(input bit scramble, output int fv_at, output int fv_cnt,
                            output int busy_n);
        fv_at  = -1;
        fv_cnt = 0;
        busy_n = 0;
        bus.sample_clk = 1'b1;
        @(posedge clk); #1;
        bus.sample_clk = 1'b0;
        if (scramble) scramble_inputs();
        for (int c = 0; c < N_CH + 8; c++) begin
            if (bus.busy) busy_n++;
            if (bus.frame_valid) begin
                fv_cnt++;
                if (fv_at < 0) fv_at = c;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int fv_at, fv_cnt, busy_n, got;
        logic [N_CH*W-1:0] exp;

        tbl[0] = '{64'h8001_5555_ABCD_1234, 8'hE4, 16'h0000, 4'h0, 8'h0F, 64'h8001_5555_ABCD_1234};
        tbl[1] = '{64'h8001_5555_ABCD_FFF8, 8'hC4, 16'h0E00, 4'h0, 8'h0F, 64'h8001_FFFE_ABCD_FFF8};
        tbl[2] = '{64'h8001_5555_ABCD_0007, 8'hC4, 16'h0E00, 4'h0, 8'h0F, 64'h8001_0001_ABCD_0007};
        tbl[3] = '{64'h8001_5555_2000_1234, 8'hE4, 16'h0030, 4'h0, 8'h0F, 64'h8001_5555_7FFF_1234};
        tbl[4] = '{64'h8001_5555_C000_1234, 8'hE4, 16'h0030, 4'h0, 8'h0F, 64'h8001_5555_8000_1234};
        tbl[5] = '{64'h8001_5555_0100_1234, 8'hE4, 16'h0030, 4'h0, 8'h0F, 64'h8001_5555_0800_1234};
        tbl[6] = '{64'h8001_5555_ABCD_1234, 8'hE5, 16'h0000, 4'h0, 8'h0D, 64'h8001_5555_0000_0000};
        tbl[7] = '{64'h8001_5555_ABCD_1234, 8'hE4, 16'h0000, 4'h8, 8'h0F, 64'h0000_5555_ABCD_1234};

        rst = 1'b0;
        bus.sample_clk = 1'b0;
        set_bus('0, '0, '0, '0, '0);
        bus3.sample_clk = 1'b0;
        bus3.sample_in  = 48'h7777_2222_1111;
        bus3.cfg_src    = 6'b10_01_11;
        bus3.cfg_shift  = '0;
        bus3.cfg_mute   = '0;
        bus3.jack       = 8'hFF;
`ifdef MIRROR_ROUTER_CRUSH_EN
        bus3.cfg_crush  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", bus.sample_out, '0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_fv", bus.frame_valid, 0);
        chk("reset_ovr", bus.overrun, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Three-channel instance: source index 3 is out of range.
        bus3.sample_clk = 1'b1;
        @(posedge clk); #1;
        bus3.sample_clk = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (bus3.frame_valid) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("n3_done", got, 1);
        chk("n3_out", bus3.sample_out, 48'h7777_2222_0000);

        for (int i = 0; i < 8; i++) begin
            set_bus(tbl[i].sin, tbl[i].src, tbl[i].shift, tbl[i].mute, tbl[i].jack);
            do_frame(1'b1, fv_at, fv_cnt, busy_n);
            chk($sformatf("vec%0d_out", i), bus.sample_out, tbl[i].exp);
            chk($sformatf("vec%0d_fv_at", i), fv_at, N_CH + 1);
            chk($sformatf("vec%0d_fv_cnt", i), fv_cnt, 1);
            chk($sformatf("vec%0d_busy", i), busy_n, N_CH + 1);
        end
        chk("table_ovr", bus.overrun, 0);

        // Reset during PROC, outputs previously 0x1234 on channel 0.
        set_bus(tbl[0].sin, tbl[0].src, tbl[0].shift, tbl[0].mute, tbl[0].jack);
        bus.sample_clk = 1'b1;
        @(posedge clk); #1;
        bus.sample_clk = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_out", bus.sample_out, '0);
        chk("mid_busy0", bus.busy, 0);
        chk("mid_fv0", bus.frame_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fv_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.frame_valid) fv_cnt++;
        end
        chk("mid_no_commit", fv_cnt, 0);
        chk("mid_out_hold", bus.sample_out, '0);

        // Second rise three clocks into a frame.
        set_bus(64'h8001_5555_ABCD_1111, 8'hE4, 16'h0000, 4'h0, 8'h0F);
        bus.sample_clk = 1'b1;
        @(posedge clk); #1;
        bus.sample_clk = 1'b0;
        @(posedge clk); #1;
        bus.sample_in[15:0] = 16'h2222;
        @(posedge clk); #1;
        bus.sample_clk = 1'b1;
        @(posedge clk); #1;
        bus.sample_clk = 1'b0;
        fv_cnt = 0;
        for (int c = 0; c < N_CH + 8; c++) begin
            if (bus.frame_valid) fv_cnt++;
            @(posedge clk); #1;
        end
        chk("ovr_out0", bus.sample_out[15:0], 16'h1111);
        chk("ovr_fv_cnt", fv_cnt, 1);
        chk("ovr_set", bus.overrun, 1);
        do_frame(1'b0, fv_at, fv_cnt, busy_n);
        chk("ovr_sticky", bus.overrun, 1);
        chk("ovr_next_out0", bus.sample_out[15:0], 16'h2222);
        rst = 1'b0;
        #1;
        chk("ovr_clear", bus.overrun, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

`ifdef MIRROR_ROUTER_CRUSH_EN
        set_bus(64'h8001_5555_FFFF_0007, 8'hE4, 16'h0000, 4'h0, 8'h0F);
        bus.cfg_crush = 16'h2222;
        do_frame(1'b0, fv_at, fv_cnt, busy_n);
        chk("crush_out", bus.sample_out, 64'h8000_5554_FFFC_0004);
`endif

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N_CH; i++) begin
                in_v[i]    = 16'($urandom);
                src_v[i]   = int'($urandom_range(0, (1 << SI) - 1));
                shift_v[i] = int'($urandom_range(0, 15)) - 8;
                mute_v[i]  = ($urandom_range(0, 5) == 0);
                crush_v[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15));
            end
            jack_v = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            drive_model_inputs();
            for (int i = 0; i < N_CH; i++) exp[i*W +: W] = model_ch(i);
            do_frame(1'b1, fv_at, fv_cnt, busy_n);
            chk($sformatf("rand%0d_out", f), bus.sample_out, exp);
            chk($sformatf("rand%0d_fv_at", f), fv_at, N_CH + 1);
        end
        chk("rand_ovr", bus.overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
